// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: FSM state encoding and default sizes.
// Optional same-cycle write bypass is enabled by defining REGFILE_BYPASS_EN.
package regfile_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int NRD_DEF   = 2;
    localparam int NWR_DEF   = 2;

    typedef logic [0:0] state_t;
    localparam state_t CLEAR = 1'b0;
    localparam state_t READY = 1'b1;

endpackage

// File: rtl/regfile_if.sv
// Bus bundle of the register file: read, write, mark and flush signals plus status outputs.
interface regfile_if
    import regfile_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NRD   = NRD_DEF,
    parameter int NWR   = NWR_DEF
);
    localparam int AW = $clog2(NREGS);

    logic                 i_flush;
    logic [NRD*AW-1:0]    i_rd_addr;
    logic [NRD*XLEN-1:0]  o_rd_data;
    logic [NRD-1:0]       o_rd_busy;
    logic [NWR-1:0]       i_wr_en;
    logic [NWR*AW-1:0]    i_wr_addr;
    logic [NWR*XLEN-1:0]  i_wr_data;
    logic                 i_mark_en;
    logic [AW-1:0]        i_mark_addr;
    logic                 o_ready;

    modport master (
        output i_flush, i_rd_addr, i_wr_en, i_wr_addr, i_wr_data, i_mark_en, i_mark_addr,
        input  o_rd_data, o_rd_busy, o_ready
    );

    modport slave (
        input  i_flush, i_rd_addr, i_wr_en, i_wr_addr, i_wr_data, i_mark_en, i_mark_addr,
        output o_rd_data, o_rd_busy, o_ready
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// Pending-bit scoreboard: marks set, committed writes clear, flush clears all; entry 0 never pends.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS = NREGS_DEF,
    parameter int NWR   = NWR_DEF,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clr_all_i,
    input  logic [NWR-1:0]    wr_vld_i,
    input  logic [NWR*AW-1:0] wr_addr_i,
    input  logic              mark_vld_i,
    input  logic [AW-1:0]     mark_addr_i,
    output logic [NREGS-1:0]  pend_o
);

    logic [NREGS-1:0] pend_q, pend_d;

    // Mark is applied after the write clears so that it wins on a collision.
    always_comb begin
        pend_d = pend_q;
        if (clr_all_i) begin
            pend_d = '0;
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (wr_vld_i[j]) pend_d[wr_addr_i[j*AW +: AW]] = 1'b0;
            end
            if (mark_vld_i) pend_d[mark_addr_i] = 1'b1;
        end
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) pend_q <= '0;
        else         pend_q <= pend_d;
    end

    assign pend_o = pend_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with scoreboard and a sweep-based clear (storage has no reset).
// Define REGFILE_BYPASS_EN to forward same-cycle committing writes to the read ports.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NRD   = NRD_DEF,
    parameter int NWR   = NWR_DEF
) (
    input  logic     i_clk,
    input  logic     i_rst_n,
    regfile_if.slave bus
);

    localparam int            AW   = $clog2(NREGS);
    localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

    state_t           state_q, state_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic [XLEN-1:0]  mem_q [NREGS];
    logic             ready;
    logic [NWR-1:0]   wr_ok;
    logic             mark_ok;
    logic [NREGS-1:0] pend;
    logic [AW-1:0]    rd_a [NRD];
    logic [AW-1:0]    wr_a [NWR];

    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (a != '0) && (int'(a) < NREGS);
    endfunction

    assign ready       = (state_q == READY);
    assign bus.o_ready = ready;

    always_comb begin
        for (int k = 0; k < NRD; k++) rd_a[k] = bus.i_rd_addr[k*AW +: AW];
        for (int j = 0; j < NWR; j++) wr_a[j] = bus.i_wr_addr[j*AW +: AW];
    end

    always_comb begin
        wr_ok = '0;
        for (int j = 0; j < NWR; j++) begin
            wr_ok[j] = ready && !bus.i_flush && bus.i_wr_en[j] && addr_ok(wr_a[j]);
        end
        mark_ok = ready && !bus.i_flush && bus.i_mark_en && addr_ok(bus.i_mark_addr);
    end

    // Sweep counter runs through every entry once, then the file opens for use.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == READY) begin
            if (bus.i_flush) begin
                state_d = CLEAR;
                cnt_d   = '0;
            end
        end else if (bus.i_flush) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            state_d = READY;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Higher-index ports are assigned later and therefore win on equal addresses.
    always_ff @(posedge i_clk) begin
        if (state_q == CLEAR) mem_q[cnt_q] <= '0;
        for (int j = 0; j < NWR; j++) begin
            if (wr_ok[j]) mem_q[wr_a[j]] <= bus.i_wr_data[j*XLEN +: XLEN];
        end
    end

    regfile_scoreboard #(
        .NREGS (NREGS),
        .NWR   (NWR),
        .AW    (AW)
    ) u_sb (
        .clk_i       (i_clk),
        .rst_ni      (i_rst_n),
        .clr_all_i   (bus.i_flush || (state_q == CLEAR)),
        .wr_vld_i    (wr_ok),
        .wr_addr_i   (bus.i_wr_addr),
        .mark_vld_i  (mark_ok),
        .mark_addr_i (bus.i_mark_addr),
        .pend_o      (pend)
    );

    always_comb begin
        bus.o_rd_data = '0;
        bus.o_rd_busy = '0;
        for (int k = 0; k < NRD; k++) begin
            if (ready && addr_ok(rd_a[k])) begin
                bus.o_rd_data[k*XLEN +: XLEN] = mem_q[rd_a[k]];
                bus.o_rd_busy[k]              = pend[rd_a[k]];
`ifdef REGFILE_BYPASS_EN
                for (int j = 0; j < NWR; j++) begin
                    if (wr_ok[j] && (wr_a[j] == rd_a[k])) begin
                        bus.o_rd_data[k*XLEN +: XLEN] = bus.i_wr_data[j*XLEN +: XLEN];
                        bus.o_rd_busy[k]              = 1'b0;
                    end
                end
                if (mark_ok && (bus.i_mark_addr == rd_a[k])) bus.o_rd_busy[k] = 1'b1;
`endif
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed testbench for regfile_mp with hand-computed expectations (32 x 32-bit, 2R/2W).
module tb_regfile_mp;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int NWR   = 2;
    localparam int AW    = 5;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_pass;

    regfile_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) bus ();

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.i_flush     = 1'b0;
        bus.i_rd_addr   = '0;
        bus.i_wr_en     = '0;
        bus.i_wr_addr   = '0;
        bus.i_wr_data   = '0;
        bus.i_mark_en   = 1'b0;
        bus.i_mark_addr = '0;
    endtask

    task automatic set_rd(input int k, input logic [AW-1:0] a);
        bus.i_rd_addr[k*AW +: AW] = a;
    endtask

    task automatic set_wr(input int j, input logic en, input logic [AW-1:0] a, input logic [31:0] d);
        bus.i_wr_en[j]              = en;
        bus.i_wr_addr[j*AW +: AW]   = a;
        bus.i_wr_data[j*XLEN +: XLEN] = d;
    endtask

    function automatic logic [31:0] rdata(input int k);
        return bus.o_rd_data[k*XLEN +: XLEN];
    endfunction

    // Counts sampled cycles with o_ready low, starting at the current sample point.
    task automatic count_low(output int n);
        n = 0;
        while (!bus.o_ready && n < 100) begin
            n++;
            tick();
            bus.i_wr_en = '0;
        end
    endtask

    initial begin
        int n;
        logic [31:0] acc;
        n_chk  = 0;
        n_pass = 0;
        idle();
        rst_n = 1'b0;

        repeat (3) tick();
        set_rd(0, 5'd5);
        #1;
        check("rst_ready", 32'(bus.o_ready), 32'd0);
        check("rst_rdata", rdata(0), 32'd0);
        check("rst_busy", 32'(bus.o_rd_busy), 32'd0);

        rst_n = 1'b1;
        count_low(n);
        check("init_low_cycles", 32'(n), 32'd32);
        check("init_ready", 32'(bus.o_ready), 32'd1);

        acc = '0;
        for (int r = 0; r < NREGS; r++) begin
            set_rd(r % 2, 5'(r));
            #1;
            acc = acc | rdata(r % 2) | 32'(bus.o_rd_busy);
        end
        check("init_all_zero", acc, 32'd0);

        set_wr(0, 1'b1, 5'd5, 32'hDEADBEEF);
        set_wr(1, 1'b1, 5'd5, 32'h12345678);
        tick();
        idle();
        set_rd(0, 5'd5);
        #1;
        check("x5_port1_wins", rdata(0), 32'h12345678);

        set_wr(0, 1'b1, 5'd1, 32'h11111111);
        set_wr(1, 1'b1, 5'd2, 32'h22222222);
        tick();
        idle();
        set_rd(0, 5'd1);
        set_rd(1, 5'd2);
        #1;
        check("x1_dual", rdata(0), 32'h11111111);
        check("x2_dual", rdata(1), 32'h22222222);

        set_wr(0, 1'b1, 5'd0, 32'hFFFFFFFF);
        set_wr(1, 1'b1, 5'd0, 32'hFFFFFFFF);
        bus.i_mark_en   = 1'b1;
        bus.i_mark_addr = 5'd0;
        tick();
        idle();
        set_rd(0, 5'd0);
        #1;
        check("x0_data", rdata(0), 32'd0);
        check("x0_busy", 32'(bus.o_rd_busy[0]), 32'd0);

        bus.i_mark_en   = 1'b1;
        bus.i_mark_addr = 5'd7;
        tick();
        idle();
        set_rd(1, 5'd7);
        #1;
        check("x7_busy_marked", 32'(bus.o_rd_busy[1]), 32'd1);
        set_wr(0, 1'b1, 5'd7, 32'hA5A5A5A5);
        tick();
        idle();
        set_rd(1, 5'd7);
        #1;
        check("x7_busy_written", 32'(bus.o_rd_busy[1]), 32'd0);
        check("x7_data", rdata(1), 32'hA5A5A5A5);

        set_rd(1, 5'd7);
        set_wr(1, 1'b1, 5'd7, 32'h5A5A5A5A);
        bus.i_mark_en   = 1'b1;
        bus.i_mark_addr = 5'd7;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("x7_mw_bypass_data", rdata(1), 32'h5A5A5A5A);
        check("x7_mw_bypass_busy", 32'(bus.o_rd_busy[1]), 32'd1);
`else
        check("x7_mw_old_data", rdata(1), 32'hA5A5A5A5);
        check("x7_mw_old_busy", 32'(bus.o_rd_busy[1]), 32'd0);
`endif
        tick();
        idle();
        set_rd(1, 5'd7);
        #1;
        check("x7_mw_busy", 32'(bus.o_rd_busy[1]), 32'd1);
        check("x7_mw_data", rdata(1), 32'h5A5A5A5A);

        set_rd(0, 5'd3);
        set_wr(0, 1'b1, 5'd3, 32'h55);
        #1;
`ifdef REGFILE_BYPASS_EN
        check("x3_same_cycle", rdata(0), 32'h55);
`else
        check("x3_same_cycle", rdata(0), 32'h0);
`endif
        tick();
        idle();
        set_rd(0, 5'd3);
        #1;
        check("x3_next_cycle", rdata(0), 32'h55);

        set_wr(0, 1'b1, 5'd9, 32'h77);
        tick();
        idle();
        bus.i_mark_en   = 1'b1;
        bus.i_mark_addr = 5'd9;
        tick();
        idle();
        set_rd(0, 5'd9);
        #1;
        check("x9_pre_data", rdata(0), 32'h77);
        check("x9_pre_busy", 32'(bus.o_rd_busy[0]), 32'd1);

        bus.i_flush = 1'b1;
        set_wr(1, 1'b1, 5'd10, 32'hBB);
        tick();
        idle();
        set_rd(0, 5'd9);
        #1;
        check("flush_ready", 32'(bus.o_ready), 32'd0);
        check("flush_rd_zero", rdata(0), 32'd0);
        set_wr(0, 1'b1, 5'd11, 32'hCC);
        count_low(n);
        check("flush_low_cycles", 32'(n), 32'd32);
        idle();
        set_rd(0, 5'd9);
        set_rd(1, 5'd10);
        #1;
        check("x9_post_data", rdata(0), 32'd0);
        check("x9_post_busy", 32'(bus.o_rd_busy[0]), 32'd0);
        check("x10_flush_wr_lost", rdata(1), 32'd0);
        set_rd(0, 5'd11);
        set_rd(1, 5'd5);
        #1;
        check("x11_clear_wr_lost", rdata(0), 32'd0);
        check("x5_swept", rdata(1), 32'd0);

        set_wr(0, 1'b1, 5'd4, 32'h44);
        tick();
        idle();
        bus.i_flush = 1'b1;
        tick();
        idle();
        repeat (10) tick();
        rst_n = 1'b0;
        #1;
        check("midsweep_rst_ready", 32'(bus.o_ready), 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        count_low(n);
        check("midsweep_low_cycles", 32'(n), 32'd32);

        set_wr(0, 1'b1, 5'd6, 32'h66);
        bus.i_mark_en   = 1'b1;
        bus.i_mark_addr = 5'd8;
        tick();
        idle();
        set_rd(0, 5'd6);
        set_rd(1, 5'd8);
        #1;
        check("x6_data", rdata(0), 32'h66);
        check("x8_busy", 32'(bus.o_rd_busy[1]), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_ready", 32'(bus.o_ready), 32'd0);
        check("async_rst_data", rdata(0), 32'd0);
        check("async_rst_busy", 32'(bus.o_rd_busy), 32'd0);
        tick();
        rst_n = 1'b1;
        count_low(n);
        idle();
        set_rd(1, 5'd8);
        #1;
        check("x8_busy_after_rst", 32'(bus.o_rd_busy[1]), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
